// File: rtl/eb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : eb_arb_pkg
// Brief  : Shared types and helpers for the elastic-buffer arbiters
//          (packet lock state, requester-index width).
// Rev    : 1.0 - initial release
// ============================================================================
package eb_arb_pkg;

    // Packet lock state: IDLE arbitrates freely, LOCKED pins the grant
    // to the owner of a packet that is in progress.
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // A single requester still needs a one-bit index port.
    localparam int c_ID_W_MIN = 1;

    // Width of a requester index for n requesters, never below c_ID_W_MIN.
    function automatic int eb_id_w(input int n);
        return (n > 1) ? $clog2(n) : c_ID_W_MIN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : eb_rr_pick
// Brief  : Combinational rotating-priority picker. Grants the first set
//          request at or above ptr, wrapping to the lowest set request.
//          Reusable by any scheduler needing round-robin selection.
// Rev    : 1.0 - initial release
// ============================================================================
module eb_rr_pick
    import eb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = eb_id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] w_hi;
    logic [N-1:0] w_src;

    // Mask off requests below ptr; if none remain, wrap to the full set
    // and take the lowest set bit of whichever set is in use.
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < N; i++) begin
            w_hi[i] = req[i] && (IW'(i) >= ptr);
        end
        w_src = (|w_hi) ? w_hi : req;
        gnt   = '0;
        idx   = '0;
        any   = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_src[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module : eb_rr_arb
// Brief  : N-to-1 round-robin arbiter feeding one registered valid/ready
//          output slot. Full throughput, no combinational t_valid->i_valid.
//          Optional packet lock (no interleaving) when EB_RR_ARB_LOCK_EN
//          is defined; otherwise arbitration is per beat.
// Rev    : 1.0 - initial release
// ============================================================================
module eb_rr_arb
    import eb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int IW = eb_id_w(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   t_valid,
    output logic [N-1:0]   t_ready,
    input  logic [N*W-1:0] t_data,
    input  logic [N-1:0]   t_last,
    output logic           i_valid,
    input  logic           i_ready,
    output logic [W-1:0]   i_data,
    output logic           i_last,
    output logic [IW-1:0]  i_id
);

    logic           r_valid;
    logic [W-1:0]   r_data;
    logic           r_last;
    logic [IW-1:0]  r_id;
    logic [IW-1:0]  r_ptr;

    logic           w_free;
    logic [N-1:0]   w_pick_gnt;
    logic [IW-1:0]  w_pick_idx;
    logic           w_pick_any;
    logic [N-1:0]   w_gnt;
    logic [IW-1:0]  w_gnt_idx;
    logic           w_acc;
    logic [W-1:0]   w_acc_data;
    logic           w_acc_last;
    logic [IW-1:0]  w_ptr_nxt;

    // The slot can take a new beat when empty or draining this cycle.
    assign w_free = ~r_valid | i_ready;

    eb_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (t_valid),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

`ifdef EB_RR_ARB_LOCK_EN
    arb_state_e     r_state;
    arb_state_e     w_state_nxt;
    logic [IW-1:0]  r_owner;
    logic [IW-1:0]  w_owner_nxt;
    logic [N-1:0]   w_own_oh;

    // While a packet is open only its owner is granted; gating with t_valid
    // keeps t_ready low during a mid-packet gap.
    always_comb begin
        w_own_oh = '0;
        for (int i = 0; i < N; i++) begin
            w_own_oh[i] = (IW'(i) == r_owner);
        end
        if (r_state == ARB_LOCKED) begin
            w_gnt     = w_own_oh & t_valid;
            w_gnt_idx = r_owner;
        end else begin
            w_gnt     = w_pick_any ? w_pick_gnt : '0;
            w_gnt_idx = w_pick_idx;
        end
    end

    // Lock state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Open a lock on an accepted non-last beat, release it on the last beat.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            ARB_IDLE: begin
                if (w_acc && !w_acc_last) begin
                    w_state_nxt = ARB_LOCKED;
                    w_owner_nxt = w_gnt_idx;
                end
            end
            ARB_LOCKED: begin
                if (w_acc && w_acc_last) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end
`else
    // Per-beat arbitration straight from the picker.
    always_comb begin
        w_gnt     = w_pick_any ? w_pick_gnt : '0;
        w_gnt_idx = w_pick_idx;
    end
`endif

    assign t_ready = w_gnt & {N{w_free}};
    assign w_acc   = |(t_valid & t_ready);

    // One-hot mux of the granted requester's beat.
    always_comb begin
        w_acc_data = '0;
        w_acc_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_acc_data = t_data[i*W +: W];
                w_acc_last = t_last[i];
            end
        end
    end

    // Next pointer is the requester after the one served, wrapping at N.
    assign w_ptr_nxt = (w_gnt_idx == IW'(N - 1)) ? '0 : w_gnt_idx + IW'(1);

    // Output slot: load on accept, empty when drained without replacement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_id    <= '0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_data  <= w_acc_data;
            r_last  <= w_acc_last;
            r_id    <= w_gnt_idx;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Round-robin pointer; with packet lock it moves only on packet ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
`ifdef EB_RR_ARB_LOCK_EN
        end else if (w_acc && w_acc_last) begin
`else
        end else if (w_acc) begin
`endif
            r_ptr <= w_ptr_nxt;
        end
    end

    assign i_valid = r_valid;
    assign i_data  = r_data;
    assign i_last  = r_last;
    assign i_id    = r_id;

endmodule
`default_nettype wire
